// File: rtl/snake_text_pkg.sv
// snake_text_pkg: shared types and character constants for the
// Snake LCD text path (score line and game-over line).
package snake_text_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    typedef enum logic {
        SCORE,
        OVER
    } msg_t;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_SP   = 8'h20;
    localparam logic [7:0] CHAR_ZERO = 8'h30;

    localparam int PFX_LEN  = 7;
    localparam int OVER_LEN = 9;

    localparam logic [7:0] SCORE_PFX [0:PFX_LEN-1] =
        '{"S", "C", "O", "R", "E", ":", " "};

    localparam logic [7:0] OVER_TXT [0:OVER_LEN-1] =
        '{"G", "A", "M", "E", " ", "O", "V", "E", "R"};

endpackage

// File: rtl/score_text_gen_if.sv
// score_text_gen_if: request side (score / game over) and the
// character strobe side of the score text generator.
interface score_text_gen_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score_in;
    logic               score_update;
    logic               game_over;
    logic               write_en;
    logic [7:0]         data;
    logic               busy;
    logic               saturated;

    modport master (
        output score_in, score_update, game_over,
        input  write_en, data, busy, saturated
    );

    modport slave (
        input  score_in, score_update, game_over,
        output write_en, data, busy, saturated
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter.
// One bit per cycle, exactly SCORE_W cycles after start.
module bin2bcd_seq #(
    parameter int SCORE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(SCORE_W);
    localparam logic [CW-1:0] LAST = CW'(SCORE_W - 1);

    logic [SCORE_W-1:0]  sh_q;
    logic [CW-1:0]       cnt_q;
    logic                run_q;
    logic [4*DIGITS-1:0] adj;

    // done is high during the cycle whose edge performs the last shift
    assign done = run_q && (cnt_q == LAST);

    // add 3 to every digit >= 5 so the following shift carries decimally
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // load on start, then one adjust-and-shift step per cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            bcd   <= '0;
        end else if (start) begin
            sh_q  <= bin;
            cnt_q <= '0;
            run_q <= 1'b1;
            bcd   <= '0;
        end else if (run_q) begin
            bcd   <= {adj[4*DIGITS-2:0], sh_q[SCORE_W-1]};
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + 1'b1;
            if (done) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/score_text_gen.sv
// score_text_gen: prints "SCORE: nnnn"+CR or "GAME OVER"+CR one char per cycle.
// Optional macro LEADING_ZERO_BLANK_EN prints leading zero digits as spaces.
module score_text_gen
    import snake_text_pkg::*;
#(
    parameter int SCORE_W = 14,
    parameter int DIGITS  = 4
) (
    input logic             clock,
    input logic             reset,
    score_text_gen_if.slave bus
);
    localparam logic [SCORE_W-1:0] SAT_MAX = SCORE_W'(10 ** DIGITS - 1);
    localparam logic [3:0] SCORE_LAST = 4'(PFX_LEN + DIGITS);
    localparam logic [3:0] OVER_LAST  = 4'(OVER_LEN);

    state_t              state_q, state_d;
    msg_t                msg_q, msg_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          last_idx;
    logic                pend_score, pend_over;
    logic                take_over, take_score;
    logic                conv_done;
    logic [4*DIGITS-1:0] bcd, shown;
    logic [SCORE_W-1:0]  score_q;
    logic                sat_q, we_q;
    logic [7:0]          data_q, ch;
`ifdef LEADING_ZERO_BLANK_EN
    logic                lead;
`endif

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clock (clock),
        .reset (reset),
        .start (take_score),
        .bin   (bus.score_in),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign last_idx      = (msg_q == OVER) ? OVER_LAST : SCORE_LAST;
    assign shown         = sat_q ? {DIGITS{4'h9}} : bcd;
    assign bus.write_en  = we_q;
    assign bus.data      = data_q;
    assign bus.saturated = sat_q;
    assign bus.busy      = (state_q != IDLE) || we_q;

    // next state: game over wins in IDLE, conversion, then line emission
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        idx_d      = idx_q;
        take_over  = 1'b0;
        take_score = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.game_over || pend_over) begin
                    take_over = 1'b1;
                    state_d   = EMIT;
                    msg_d     = OVER;
                    idx_d     = '0;
                end else if (bus.score_update || pend_score) begin
                    take_score = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = EMIT;
                    msg_d   = SCORE;
                    idx_d   = '0;
                end
            end
            EMIT: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == last_idx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // character for the current line position
    always_comb begin
        ch = CHAR_CR;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
`endif
        if (msg_q == OVER) begin
            if (idx_q < 4'(OVER_LEN)) ch = OVER_TXT[idx_q];
        end else if (idx_q < 4'(PFX_LEN)) begin
            ch = SCORE_PFX[idx_q[2:0]];
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
                lead = lead && (shown[4*(DIGITS-1-i) +: 4] == 4'h0);
`endif
                if (idx_q == 4'(PFX_LEN + i)) begin
                    ch = CHAR_ZERO | {4'h0, shown[4*(DIGITS-1-i) +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
                    if (lead && (i != DIGITS - 1)) ch = CHAR_SP;
`endif
                end
            end
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= SCORE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
        end
    end

    // strobes, latched score, saturation flag and request merging
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q       <= 1'b0;
            data_q     <= 8'h00;
            score_q    <= '0;
            sat_q      <= 1'b0;
            pend_score <= 1'b0;
            pend_over  <= 1'b0;
        end else begin
            we_q <= (state_q == EMIT);
            if (state_q == EMIT) data_q <= ch;
            if (take_score) score_q <= bus.score_in;
            if ((state_q == CONV) && conv_done) sat_q <= (score_q > SAT_MAX);
            if (state_q != IDLE) begin
                pend_score <= pend_score | bus.score_update;
                pend_over  <= pend_over | bus.game_over;
            end else if (take_over) begin
                pend_over  <= 1'b0;
                pend_score <= pend_score | bus.score_update;
            end else if (take_score) begin
                pend_score <= 1'b0;
            end
        end
    end
endmodule

// File: doc/score_text_gen.md
Name: score_text_gen

Overview:
Upstream character source for the 16x2 character-LCD line driver in the Snake design. Converts the binary game score to decimal ASCII with a sequential shift-add-3 converter and emits a text line one character per cycle as write_en/data strobes. Also emits a fixed "GAME OVER" line. Every line ends with CR (0x0D) so the downstream driver scrolls line 2 into line 1.

Parameters:
- SCORE_W, 14, binary score width; converter runs exactly SCORE_W cycles.
- DIGITS, 4, decimal digits shown; scores above 10^DIGITS-1 saturate to all '9'.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- score_in  in  SCORE_W  binary score, sampled on accepted score_update
- score_update  in  1  single-cycle request to print the score line
- game_over  in  1  single-cycle request to print the game-over line
- write_en  out  1  one-cycle strobe, data valid
- data  out  8  ASCII character
- busy  out  1  high while converting or emitting
- saturated  out  1  last printed score exceeded 10^DIGITS-1

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: write_en=0, data=8'h00, busy=0, saturated=0, state=IDLE, pending flags cleared. Reset mid-line aborts immediately; the partial line is not completed.
- States: IDLE, CONV, EMIT.
- IDLE: game_over has priority. Accept it -> EMIT with msg=OVER. Else accept score_update -> latch score_in, clear BCD register -> CONV. A coincident score_update in the same cycle sets pend_score.
- CONV: double-dabble, one bit per cycle, exactly SCORE_W cycles, then -> EMIT with msg=SCORE. Saturation compare is done on the latched binary value. saturated updates at CONV exit.
- EMIT: 4-bit char index from 0. One char per cycle, with write_en=1 every cycle in EMIT.
  - SCORE line: 'S','C','O','R','E',':',' ', DIGITS digits MSD first (0x30+digit), 0x0D. 12 chars at default.
  - OVER line: 'G','A','M','E',' ','O','V','E','R',0x0D. 10 chars.
  - After CR -> IDLE.
- Latency:
  - Score: first write_en is high in the cycle after edge E0+SCORE_W+1, where E0 is the accepting edge.
  - Game over: first write_en is high after edge E0+1.
- busy=1 from the cycle after acceptance until the cycle after CR. busy=0 in the CR cycle's successor.
- Requests while busy:
  - score_update sets pend_score. Multiple requests coalesce, and score_in is re-sampled when the pending request is served.
  - game_over sets pend_over.
- On return to IDLE, serve pend_over first, then pend_score, one per IDLE cycle. Requests are never dropped, only merged.
- write_en is never high outside EMIT. data holds its last value when write_en=0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are emitted as 0x20 (space). The least-significant digit is always a numeral, so score 0 prints "   0". Line length is unchanged.
- Undefined: zero-padded digits, e.g. "0305".

Decomposition:
- Package snake_text_pkg holds:
  - State enum: IDLE, CONV, EMIT.
  - Message-select enum: SCORE, OVER.
  - Constants CHAR_CR=8'h0D, CHAR_SP=8'h20, CHAR_ZERO=8'h30.
  - Constant char arrays for the "SCORE: " prefix and the "GAME OVER" text.
- Sub-module bin2bcd_seq implements the shift-add-3 converter.
  - Inputs: start, bin.
  - Outputs: done, bcd[4*DIGITS-1:0].
  - Fixed SCORE_W-cycle latency.

Test Plan:
- Reset, then score_in=305, pulse score_update -> after 15 edges, 12 consecutive strobes "SCORE: 0305"+0x0D; busy low afterwards; saturated=0.
- score_in=12345 -> digits "9999", saturated=1; next update with score_in=7 -> "0007" (or "   7" with LEADING_ZERO_BLANK_EN), saturated=0.
- game_over pulse in IDLE -> strobes start after 1 edge: "GAME OVER"+0x0D, 10 strobes, no CONV cycles.
- Coincident game_over+score_update (score 42) -> OVER line first, then score line "0042" beginning one IDLE cycle later.
- Three score_update pulses during one EMIT, score_in changing 10->20->30 -> exactly one extra line, showing "0030".
- reset asserted at the 5th strobe -> next cycle write_en=0, busy=0, data=0; a new score_update is accepted normally.
